load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter DEPTH, default 32, giving the number of 64-bit words in the attached data memory.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the completed-operation counter.
REQ-003 Port Clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port Rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port ReqValid, input, 1: request present.
REQ-006 Port ReqReady, output, 1: block accepts a request this cycle.
REQ-007 Port ReqWrite, input, 1: 1 = store, 0 = load.
REQ-008 Port ReqAddr, input, 64: byte address.
REQ-009 Port ReqData, input, 64: store data.
REQ-010 Port RspValid, output, 1: response present.
REQ-011 Port RspReady, input, 1: consumer takes the response.
REQ-012 Port RspData, output, 64: load data; 0 for stores and errors.
REQ-013 Port RspError, output, 1: request rejected, no memory access made.
REQ-014 Port MemAddress, output, 64: word index to the memory.
REQ-015 Port MemDataInput, output, 64: write data to the memory.
REQ-016 Port MemWrite, output, 1: memory write strobe.
REQ-017 Port MemRead, output, 1: memory read strobe.
REQ-018 Port MemDataOutput, input, 64: memory read data, registered by the memory on the Clk edge that samples MemRead.
REQ-019 Port OpCount, output, CNT_W: count of completed response handshakes.

Function
REQ-020 The FSM SHALL have the states IDLE, WRITE, READ, WAIT and RESP; all outputs SHALL be registered or decoded from state only.
REQ-021 ReqReady SHALL be 1 only in IDLE, and a request SHALL be accepted on an edge where ReqValid=1 and ReqReady=1.
REQ-022 On accept, the word index SHALL be ReqAddr[63:3], and an error SHALL be raised if ReqAddr[2:0]!=0 or ReqAddr[63:3]>=DEPTH.
REQ-023 On accept with error: the next state SHALL be RESP with RspError=1 and RspData=0, and MemWrite and MemRead SHALL never assert for that request.
REQ-024 On accept of a valid store: the next state SHALL be WRITE, driving MemWrite=1, MemAddress=index and MemDataInput=ReqData for exactly one cycle, followed by RESP with RspData=0 and RspError=0.
REQ-025 On accept of a valid load: the next state SHALL be READ, driving MemRead=1 and MemAddress=index for exactly one cycle, followed by WAIT.
REQ-026 In WAIT, the block SHALL capture MemDataOutput into RspData on the closing edge, then go to RESP with RspError=0.
REQ-027 Latency from the accept edge at cycle T SHALL be: store, RspValid high in T+2; load, RspValid high in T+3; error, RspValid high in T+1.
REQ-028 In RESP, RspValid SHALL be 1 and RspData and RspError SHALL be held stable until RspReady=1, after which the state SHALL return to IDLE on that edge.
REQ-029 RspValid SHALL fall in the cycle after the handshake, and a new request SHALL be acceptable from that cycle.
REQ-030 Outside WRITE and READ, MemWrite and MemRead SHALL be 0 and MemAddress and MemDataInput SHALL be 0; MemWrite and MemRead SHALL never both be 1.
REQ-031 ReqValid SHALL be ignored in every state except IDLE.
REQ-032 OpCount SHALL increment by 1 on each RspValid&&RspReady edge, error responses included, and SHALL wrap from 2^CNT_W-1 to 0.
REQ-033 ReqAddr[63:3] SHALL be compared as a full 64-bit value, with no truncation before the range check.

Reset
REQ-034 While Rst_n=0, the state SHALL be IDLE, and ReqReady SHALL be 0 while Rst_n=0.
REQ-035 While Rst_n=0, RspValid, RspError, MemWrite and MemRead SHALL be 0, and RspData, MemAddress, MemDataInput and OpCount SHALL be 0, all taking effect immediately without a clock.
REQ-036 Reset asserted mid-operation SHALL abort it: a pending response SHALL be discarded and an in-flight MemWrite SHALL drop immediately.
REQ-037 ReqReady SHALL rise on the first Clk edge after Rst_n deasserts.

Verification
REQ-038 Store ReqAddr=0x10, ReqData=0xDEADBEEF00000001 -> one cycle of MemWrite=1 with MemAddress=2, then RspValid with RspData=0, RspError=0, and OpCount=1.
REQ-039 Load ReqAddr=0x10 after REQ-038, with a memory model -> MemRead=1 for one cycle, RspData=0xDEADBEEF00000001 in T+3.
REQ-040 Misaligned ReqAddr=0x0C, then out-of-range ReqAddr=0x100 (index 32) -> RspError=1 and RspData=0 for each, with MemWrite and MemRead never asserted.
REQ-041 Hold RspReady=0 for 5 cycles in RESP while ReqValid=1 -> RspValid and RspData stable, ReqReady=0, no second accept; on RspReady=1 the block returns to IDLE.
REQ-042 Assert Rst_n=0 during the WRITE cycle -> MemWrite falls without a clock edge, RspValid never rises, and OpCount=0.
REQ-043 Complete 65536 back-to-back error requests with CNT_W=16 -> OpCount wraps to 0.

Source files
------------

// File: rtl/load_store_unit.sv
// Single-port load/store front end for a DEPTH x 64-bit word memory.
// Requests are range/alignment checked, then issued as one memory strobe.
module load_store_unit #(
  parameter int DEPTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             ReqValid,
  output logic             ReqReady,
  input  logic             ReqWrite,
  input  logic [63:0]      ReqAddr,
  input  logic [63:0]      ReqData,
  output logic             RspValid,
  input  logic             RspReady,
  output logic [63:0]      RspData,
  output logic             RspError,
  output logic [63:0]      MemAddress,
  output logic [63:0]      MemDataInput,
  output logic             MemWrite,
  output logic             MemRead,
  input  logic [63:0]      MemDataOutput,
  output logic [CNT_W-1:0] OpCount
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WRITE = 3'd1;
  localparam logic [2:0] READ  = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic             ready_q, ready_d;
  logic [63:0]      addr_q, addr_d;
  logic [63:0]      wdata_q, wdata_d;
  logic [63:0]      rsp_data_q, rsp_data_d;
  logic             rsp_error_q, rsp_error_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic        accept;
  logic [63:0] req_index;
  logic        req_error;

  // Index is zero-extended to 64 bits so no upper address bit escapes the range check.
  assign req_index = {3'b000, ReqAddr[63:3]};
  assign req_error = (ReqAddr[2:0] != 3'b000) || (req_index >= 64'(DEPTH));
  assign accept    = ReqValid && ReqReady;

  always_comb begin
    state_d     = state_q;
    ready_d     = 1'b1;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = rsp_error_q;
    op_count_d  = op_count_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d      = req_index;
          wdata_d     = ReqData;
          rsp_data_d  = 64'd0;
          rsp_error_d = req_error;
          if (req_error)     state_d = RESP;
          else if (ReqWrite) state_d = WRITE;
          else               state_d = READ;
        end
      end
      WRITE: state_d = RESP;
      READ:  state_d = WAIT;
      // Memory registered its data on the READ edge, so it is valid throughout WAIT.
      WAIT: begin
        rsp_data_d = MemDataOutput;
        state_d    = RESP;
      end
      RESP: begin
        if (RspReady) begin
          state_d    = IDLE;
          op_count_d = op_count_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ready_q keeps ReqReady low during reset and raises it on the first edge afterwards.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      addr_q      <= 64'd0;
      wdata_q     <= 64'd0;
      rsp_data_q  <= 64'd0;
      rsp_error_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
      op_count_q  <= op_count_d;
    end
  end

  assign ReqReady     = ready_q && (state_q == IDLE);
  assign RspValid     = (state_q == RESP);
  assign RspData      = rsp_data_q;
  assign RspError     = rsp_error_q;
  assign MemWrite     = (state_q == WRITE);
  assign MemRead      = (state_q == READ);
  assign MemAddress   = ((state_q == WRITE) || (state_q == READ)) ? addr_q : 64'd0;
  assign MemDataInput = (state_q == WRITE) ? wdata_q : 64'd0;
  assign OpCount      = op_count_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a word-array reference model.
// A narrow counter width keeps the wrap-around test short.
module tb_load_store_unit;

  localparam int DEPTH = 32;
  localparam int CW    = 8;
  localparam int AW    = $clog2(DEPTH);

  logic          Clk;
  logic          Rst_n;
  logic          ReqValid;
  logic          ReqReady;
  logic          ReqWrite;
  logic [63:0]   ReqAddr;
  logic [63:0]   ReqData;
  logic          RspValid;
  logic          RspReady;
  logic [63:0]   RspData;
  logic          RspError;
  logic [63:0]   MemAddress;
  logic [63:0]   MemDataInput;
  logic          MemWrite;
  logic          MemRead;
  logic [63:0]   MemDataOutput;
  logic [CW-1:0] OpCount;

  logic [63:0] mem    [DEPTH];
  logic [63:0] refMem [DEPTH];
  int checkCount;
  int passCount;
  int refOps;

  load_store_unit #(.DEPTH(DEPTH), .CNT_W(CW)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
    .ReqAddr(ReqAddr), .ReqData(ReqData),
    .RspValid(RspValid), .RspReady(RspReady), .RspData(RspData), .RspError(RspError),
    .MemAddress(MemAddress), .MemDataInput(MemDataInput),
    .MemWrite(MemWrite), .MemRead(MemRead), .MemDataOutput(MemDataOutput),
    .OpCount(OpCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Attached synchronous memory: read data registered on the edge that samples MemRead.
  always @(posedge Clk) begin
    if (MemRead)  MemDataOutput <= mem[MemAddress[AW-1:0]];
    if (MemWrite) mem[MemAddress[AW-1:0]] <= MemDataInput;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  // One full request/response; the model decides outcome and latency from address rules alone.
  task automatic applyStimulus(input bit isWrite, input logic [63:0] addr, input logic [63:0] data,
                               input int holdCycles);
    logic [63:0] idx;
    logic [63:0] expData;
    bit err;
    int expLat, lat, nWr, nRd, w;
    idx     = addr >> 3;
    err     = (addr[2:0] != 3'b000) || (idx >= 64'(DEPTH));
    expLat  = err ? 1 : (isWrite ? 2 : 3);
    expData = (err || isWrite) ? 64'd0 : refMem[idx[AW-1:0]];
    if (!err && isWrite) refMem[idx[AW-1:0]] = data;

    @(negedge Clk);
    ReqValid = 1'b1; ReqWrite = isWrite; ReqAddr = addr; ReqData = data; RspReady = 1'b0;
    w = 0;
    while (!ReqReady && w < 20) begin
      @(negedge Clk);
      w++;
    end
    checkOutput("reqReady", 64'(ReqReady), 64'd1);
    @(posedge Clk);
    #1;
    ReqValid = 1'b0;

    lat = 0; nWr = 0; nRd = 0;
    do begin
      @(negedge Clk);
      lat++;
      if (MemWrite) begin
        nWr++;
        checkOutput("memAddrW", MemAddress, idx);
        checkOutput("memWdata", MemDataInput, data);
      end
      if (MemRead) begin
        nRd++;
        checkOutput("memAddrR", MemAddress, idx);
      end
      ReqValid = 1'($urandom);
      ReqWrite = 1'($urandom);
      ReqAddr  = {32'd0, $urandom} & 64'hFF;
    end while (!RspValid && lat < 10);

    checkOutput("latency",  64'(lat), 64'(expLat));
    checkOutput("nWrite",   64'(nWr), 64'(!err && isWrite));
    checkOutput("nRead",    64'(nRd), 64'(!err && !isWrite));
    checkOutput("rspData",  RspData, expData);
    checkOutput("rspError", 64'(RspError), 64'(err));

    for (int h = 0; h < holdCycles; h++) begin
      ReqValid = 1'b1;
      @(negedge Clk);
      checkOutput("holdValid", 64'(RspValid), 64'd1);
      checkOutput("holdData",  RspData, expData);
      checkOutput("holdError", 64'(RspError), 64'(err));
      checkOutput("holdReady", 64'(ReqReady), 64'd0);
    end

    RspReady = 1'b1;
    ReqValid = 1'b0;
    @(negedge Clk);
    RspReady = 1'b0;
    refOps++;
    checkOutput("postValid", 64'(RspValid), 64'd0);
    checkOutput("postReady", 64'(ReqReady), 64'd1);
    checkOutput("postStrobe", 64'({MemWrite, MemRead}), 64'd0);
    checkOutput("postMemAddr", MemAddress, 64'd0);
    checkOutput("opCount", 64'(OpCount), 64'(refOps % (1 << CW)));
  endtask

  initial begin
    logic [63:0] a;
    int kind;
    checkCount = 0; passCount = 0; refOps = 0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 64'd0;
      refMem[i] = 64'd0;
    end
    MemDataOutput = 64'd0;
    Rst_n = 1'b0; ReqValid = 1'b0; ReqWrite = 1'b0; ReqAddr = 64'd0; ReqData = 64'd0; RspReady = 1'b0;

    repeat (3) @(negedge Clk);
    checkOutput("rstReady",   64'(ReqReady), 64'd0);
    checkOutput("rstValid",   64'(RspValid), 64'd0);
    checkOutput("rstStrobe",  64'({MemWrite, MemRead, RspError}), 64'd0);
    checkOutput("rstData",    RspData, 64'd0);
    checkOutput("rstMemAddr", MemAddress, 64'd0);
    checkOutput("rstMemData", MemDataInput, 64'd0);
    checkOutput("rstOpCount", 64'(OpCount), 64'd0);
    Rst_n = 1'b1;
    #1;
    checkOutput("releaseReady0", 64'(ReqReady), 64'd0);
    @(negedge Clk);
    checkOutput("releaseReady1", 64'(ReqReady), 64'd1);

    applyStimulus(1'b1, 64'h10, 64'hDEADBEEF00000001, 0);
    applyStimulus(1'b0, 64'h10, 64'd0, 0);
    applyStimulus(1'b1, 64'h0C, 64'h1234, 0);
    applyStimulus(1'b0, 64'h100, 64'd0, 0);
    applyStimulus(1'b1, 64'((DEPTH - 1) * 8), 64'hA5A5A5A5A5A5A5A5, 5);
    applyStimulus(1'b0, 64'((DEPTH - 1) * 8), 64'd0, 5);
    applyStimulus(1'b0, 64'h8000_0000_0000_0010, 64'd0, 0);
    applyStimulus(1'b1, 64'h0000_0100_0000_0008, 64'h77, 2);

    for (int n = 0; n < 80; n++) begin
      kind = int'($urandom_range(0, 4));
      case (kind)
        0, 1: a = 64'($urandom_range(0, DEPTH - 1)) << 3;
        2:    a = (64'($urandom_range(0, DEPTH - 1)) << 3) | 64'($urandom_range(1, 7));
        3:    a = 64'($urandom_range(DEPTH, 4 * DEPTH)) << 3;
        default: a = ({$urandom, $urandom} | 64'h0000_0001_0000_0000) & ~64'h7;
      endcase
      applyStimulus(1'($urandom), a, {$urandom, $urandom}, int'($urandom_range(0, 3)));
    end

    // Reset landing in the WRITE cycle must abort the store before it reaches memory.
    @(negedge Clk);
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 64'h18; ReqData = 64'hBAD0BAD0BAD0BAD0;
    @(posedge Clk);
    #1;
    ReqValid = 1'b0;
    #1;
    checkOutput("midWrite", 64'(MemWrite), 64'd1);
    Rst_n = 1'b0;
    #1;
    refOps = 0;
    checkOutput("abortWrite",   64'(MemWrite), 64'd0);
    checkOutput("abortMemAddr", MemAddress, 64'd0);
    checkOutput("abortMemData", MemDataInput, 64'd0);
    checkOutput("abortOpCount", 64'(OpCount), 64'd0);
    checkOutput("abortReady",   64'(ReqReady), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      checkOutput("abortValid", 64'(RspValid), 64'd0);
    end
    Rst_n = 1'b1;
    @(negedge Clk);
    checkOutput("reReady", 64'(ReqReady), 64'd1);
    applyStimulus(1'b0, 64'h18, 64'd0, 0);

    refOps = 0;
    Rst_n = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    for (int n = 0; n < (1 << CW); n++) applyStimulus(1'($urandom), 64'h4 + 64'(n * 8), 64'd0, 0);
    checkOutput("opCountWrap", 64'(OpCount), 64'(refOps % (1 << CW)));

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
